// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit turning a pipeline access into one
// request/response bus transaction, stalling the pipeline until it completes.
module mem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic [2:0]        ex_funct3,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic              pipe_hold,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic              m_req_write,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [31:0]       m_req_wdata,
    output logic [3:0]        m_req_wstrb,
    input  logic              m_resp_valid,
    input  logic [31:0]       m_resp_rdata,
    output logic [31:0]       mem_rdata,
    output logic              lsu_stall,
    output logic              access_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t state, state_nx;
    logic access, legal, aligned, ok;
    logic [2:0] f3_q;
    logic [1:0] sel_q;
    logic [3:0] strb;
    logic [31:0] wdata, ext;
    logic [7:0] b;
    logic [15:0] h;
    assign access  = ex_memread | ex_memwrite;
    assign legal   = ex_memwrite ? (ex_funct3 inside {3'b000, 3'b001, 3'b010})
                                 : (ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign aligned = ex_funct3[1:0] == 2'b01 ? ~ex_addr[0] :
                     ex_funct3[1:0] == 2'b10 ? ex_addr[1:0] == 2'b00 : 1'b1;
    assign ok      = access & legal & aligned;
    assign strb    = !ex_memwrite ? 4'b0000 :
                     ex_funct3[1:0] == 2'b00 ? 4'b0001 << ex_addr[1:0] :
                     ex_funct3[1:0] == 2'b01 ? 4'b0011 << ex_addr[1:0] : 4'b1111;
    assign wdata   = ex_funct3[1:0] == 2'b00 ? {4{ex_wdata[7:0]}} :
                     ex_funct3[1:0] == 2'b01 ? {2{ex_wdata[15:0]}} : ex_wdata;
    // Lane select comes from the captured offset, not the live pipeline address.
    assign b       = m_resp_rdata[8*sel_q +: 8];
    assign h       = m_resp_rdata[16*sel_q[1] +: 16];
    assign ext     = f3_q[1:0] == 2'b00 ? {{24{b[7] & ~f3_q[2]}}, b} :
                     f3_q[1:0] == 2'b01 ? {{16{h[15] & ~f3_q[2]}}, h} : m_resp_rdata;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (ok ? REQ : IDLE) :
                   state == REQ  ? (m_req_ready ? RESP : REQ) :
                   state == RESP ? (m_resp_valid ? DONE : RESP) :
                                   (pipe_hold ? DONE : IDLE);
    end

    always_comb begin
        m_req_valid = state == REQ;
        lsu_stall   = (state == IDLE && ok) || state == REQ || state == RESP;
        access_err  = state == IDLE && access && !ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_req_write <= 1'b0;
            m_req_addr  <= '0;
            m_req_wdata <= '0;
            m_req_wstrb <= '0;
            f3_q        <= '0;
            sel_q       <= '0;
            mem_rdata   <= '0;
        end else begin
            if (state == IDLE && ok) begin
                m_req_write <= ex_memwrite;
                m_req_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
                m_req_wdata <= wdata;
                m_req_wstrb <= strb;
                f3_q        <= ex_funct3;
                sel_q       <= ex_addr[1:0];
            end
            if (state == RESP && m_resp_valid && !m_req_write) mem_rdata <= ext;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized scoreboard bench for mem_lsu with a responder bus model.
module tb_mem_lsu;
    logic clk = 0, rst = 1;
    logic ex_memread = 0, ex_memwrite = 0, pipe_hold = 0;
    logic [2:0] ex_funct3 = 0;
    logic [31:0] ex_addr = 0, ex_wdata = 0;
    logic m_req_valid, m_req_ready, m_req_write, m_resp_valid;
    logic [31:0] m_req_addr, m_req_wdata, m_resp_rdata, mem_rdata;
    logic [3:0] m_req_wstrb;
    logic lsu_stall, access_err;

    typedef struct { bit wr; logic [31:0] addr, wdata; logic [3:0] strb; } req_t;
    typedef struct { bit err; logic [31:0] rd; int stall; } ret_t;
    typedef struct { int rdy, rsp; logic [31:0] rdata; } bus_t;
    req_t req_q[$];
    ret_t ret_q[$];
    bus_t bus_q[$];
    int n_chk = 0, n_fail = 0;
    logic [31:0] last_rd = 0;

    mem_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .pipe_hold(pipe_hold),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_write(m_req_write),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata), .mem_rdata(mem_rdata),
        .lsu_stall(lsu_stall), .access_err(access_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Reference: access size from funct3, lanes and extension by plain arithmetic.
    function automatic void model(input bit wr, input bit [2:0] f3, input logic [31:0] a, wd, rd,
                                  output bit err, output logic [3:0] strb,
                                  output logic [31:0] wdo, output logic [31:0] ld);
        int sz, off;
        logic [31:0] v;
        sz  = 1 << f3[1:0];
        off = int'(a[1:0]);
        err = (wr ? f3 > 2 : (f3 == 3 || f3 > 5)) || (a % sz != 0);
        for (int i = 0; i < 4; i++) begin
            strb[i] = wr && i >= off && i < off + sz;
            wdo[8*i +: 8] = wd[8*(i % sz) +: 8];
        end
        v = rd >> (8 * off);
        if (sz == 1)      ld = f3[2] ? {24'b0, v[7:0]} : 32'($signed(v[7:0]));
        else if (sz == 2) ld = f3[2] ? {16'b0, v[15:0]} : 32'($signed(v[15:0]));
        else              ld = rd;
    endfunction

    task automatic issue(input bit rd, input bit wr, input bit [2:0] f3, input logic [31:0] a, wd,
                         rdata, input int rdy, input int rsp, input int hold);
        bit err;
        logic [3:0] strb;
        logic [31:0] wdo, ld;
        int n;
        model(wr, f3, a, wd, rdata, err, strb, wdo, ld);
        if (!err) begin
            req_q.push_back('{wr, a & 32'hFFFF_FFFC, wdo, strb});
            bus_q.push_back('{rdy, rsp, rdata});
            if (!wr) last_rd = ld;
        end
        ret_q.push_back('{err, last_rd, err ? 0 : 3 + rdy + rsp});
        ex_memread = rd; ex_memwrite = wr; ex_funct3 = f3; ex_addr = a; ex_wdata = wd;
        pipe_hold = !err && hold > 0;
        #1;
        n = 0;
        while (lsu_stall && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) bad("stall_timeout");
        repeat (pipe_hold ? hold : 0) begin @(posedge clk); #1; end
        pipe_hold = 0;
        @(posedge clk); #1;
        ex_memread = 0; ex_memwrite = 0;
    endtask

    // Bus responder: ready after rdy cycles of valid, response rsp cycles after handshake.
    int bphase = 0, bcnt = 0;
    initial begin
        m_req_ready = 0; m_resp_valid = 0; m_resp_rdata = 0;
        forever begin
            @(posedge clk); #1;
            m_req_ready = 0; m_resp_valid = 0; m_resp_rdata = $urandom;
            if (bphase == 0) begin
                if (m_req_valid && bus_q.size() > 0) begin
                    if (bcnt >= bus_q[0].rdy) begin m_req_ready = 1; bphase = 1; bcnt = 0; end
                    else bcnt++;
                end
            end else if (bcnt >= bus_q[0].rsp) begin
                m_resp_valid = 1; m_resp_rdata = bus_q[0].rdata;
                void'(bus_q.pop_front());
                bphase = 0; bcnt = 0;
            end else bcnt++;
        end
    end

    int scnt = 0;
    bit pv = 0;
    logic [68:0] prev;
    req_t rq;
    ret_t rt;
    always @(negedge clk) begin
        if (rst) begin
            scnt = 0; pv = 0;
        end else begin
            if (lsu_stall) scnt++;
            if (!lsu_stall) chk("req_valid_without_stall", m_req_valid, 0);
            if (pv && m_req_valid) chk("req_stable", {m_req_write, m_req_addr, m_req_wdata, m_req_wstrb}, prev);
            if (m_req_valid && m_req_ready) begin
                if (req_q.size() == 0) bad("unexpected_handshake");
                else begin
                    rq = req_q.pop_front();
                    chk("req_write", m_req_write, rq.wr);
                    chk("req_addr", m_req_addr, rq.addr);
                    chk("req_wstrb", m_req_wstrb, rq.strb);
                    if (rq.wr) chk("req_wdata", m_req_wdata, rq.wdata);
                end
            end
            pv = m_req_valid && !m_req_ready;
            prev = {m_req_write, m_req_addr, m_req_wdata, m_req_wstrb};
            if ((ex_memread || ex_memwrite) && !lsu_stall) begin
                if (ret_q.size() == 0) bad("unexpected_retire");
                else if (pipe_hold) chk("held_rdata", mem_rdata, ret_q[0].rd);
                else begin
                    rt = ret_q.pop_front();
                    chk("access_err", access_err, rt.err);
                    chk("mem_rdata", mem_rdata, rt.rd);
                    chk("stall_cycles", scnt, rt.stall);
                    scnt = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    bit krd, kwr;
    bit [2:0] f3;
    int k;
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", m_req_valid, 0);
        chk("rst_req_write", m_req_write, 0);
        chk("rst_req_addr", m_req_addr, 0);
        chk("rst_req_wdata", m_req_wdata, 0);
        chk("rst_req_wstrb", m_req_wstrb, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_stall", lsu_stall, 0);
        rst = 0;
        @(posedge clk); #1;
        issue(1, 0, 3'b000, 32'h103, 0, 32'h80FF_1234, 0, 0, 0);
        chk("lb_result", mem_rdata, 32'hFFFF_FF80);
        issue(0, 1, 3'b001, 32'h202, 32'h0000_BEEF, 0, 0, 0, 0);
        issue(1, 0, 3'b010, 32'h300, 0, 32'h1357_9BDF, 4, 3, 0);
        issue(1, 0, 3'b101, 32'h006, 0, 32'h9ABC_0000, 0, 0, 2);
        chk("lhu_result", mem_rdata, 32'h0000_9ABC);
        issue(1, 0, 3'b010, 32'h001, 0, 0, 0, 0, 0);
        issue(1, 0, 3'b011, 32'h008, 0, 0, 0, 0, 0);
        issue(1, 1, 3'b000, 32'h011, 32'h0000_00A5, 0, 1, 0, 0);
        // Reset in RESP, then a stray response arrives while idle.
        req_q.push_back('{0, 32'h40, 0, 4'b0000});
        bus_q.push_back('{0, 3, 32'hDEAD_BEEF});
        ex_memread = 1; ex_funct3 = 3'b010; ex_addr = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; ex_memread = 0;
        @(posedge clk); #1;
        rst = 0;
        last_rd = 0;
        chk("rst_mid_valid", m_req_valid, 0);
        chk("rst_mid_stall", lsu_stall, 0);
        chk("rst_mid_rdata", mem_rdata, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("stray_resp_ignored", mem_rdata, 0);
        issue(1, 0, 3'b100, 32'h0F2, 0, 32'h00C3_0000, 1, 0, 0);
        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 2);
            kwr = k != 0;
            krd = k != 1;
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                f3 = 3'($urandom_range(0, 2));
                if (!kwr && $urandom_range(0, 1) == 1) f3 = f3 == 3'd2 ? 3'd4 : f3 | 3'b100;
            end
            issue(krd, kwr, f3, 32'($urandom_range(0, 1023)), $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        repeat (4) @(posedge clk);
        #1;
        chk("req_q_drained", req_q.size(), 0);
        chk("ret_q_drained", ret_q.size(), 0);
        chk("bus_q_drained", bus_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
